// File: rtl/ctrl_pkg.sv
// ctrl_pkg
//   Shared types and constants for the multi-cycle RISC-V control unit:
//   FSM state encoding, decoded opcodes, ALU operation codes and the
//   select encodings of the datapath muxes driven by the controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Memory address select
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder
//   Combinational funct3/funct7 decode for R- and I-type ALU instructions.
//   Ports:
//     funct3_i    instruction bits [14:12]
//     funct7b5_i  instruction bit 30 (selects SUB for R-type funct3=000)
//     is_rtype_i  instruction is R-type (I-type never subtracts)
//     alu_op_o    ALU operation
//     valid_o     funct3 maps to a supported operation
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output alu_op_e    alu_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct3_i)
      3'b000:  alu_op_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_op_o = ALU_AND;
      3'b110:  alu_op_o = ALU_OR;
      3'b100:  alu_op_o = ALU_XOR;
      3'b010:  alu_op_o = ALU_SLT;
      3'b001:  alu_op_o = ALU_SLL;
      3'b101:  alu_op_o = ALU_SRL;
      default: valid_o  = 1'b0;   // 011 (SLTU) is not supported
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   FSM that sequences each instruction of the multi-cycle RISC-V core over
//   3-5 cycles and drives the datapath mux selects and write enables.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     Instr           instruction register contents
//     EQ              ALU zero flag (branch resolution)
//     MemReady        shared memory completes the current access
//     PCWrite/IRWrite PC and IR/OldPC load enables
//     AdrSrc          memory address select
//     MemWrite        memory write request
//     RegWrite        register file write enable
//     ResultSrc       result bus select
//     ALUsrcA/B       ALU operand selects
//     ImmSrc          immediate format
//     ALUctrl         ALU operation
//     InstrRetired    pulse in an instruction's last cycle
//     Illegal         sticky unsupported-instruction flag
//
//   state      | meaning
//   FETCH      | read instruction at PC, PC <= PC+4 when memory ready
//   DECODE     | decode, precompute branch/jump target into ALUOut
//   MEMADR     | compute load/store effective address
//   MEMREAD    | load access, wait for memory
//   MEMWB      | write loaded data to rd
//   MEMWRITE   | store access, wait for memory
//   EXEC_R     | rs1 op rs2
//   EXEC_I     | rs1 op imm
//   ALUWB      | write ALUOut to rd
//   BRANCH     | compare rs1/rs2, load PC with target if taken
//   JAL        | PC <= target, ALUOut <= OldPC+4
//   ILLEGAL    | unsupported instruction, halted until reset
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     Instr,
  input  logic                      EQ,
  input  logic                      MemReady,
  output logic                      PCWrite,
  output logic                      IRWrite,
  output logic                      AdrSrc,
  output logic                      MemWrite,
  output logic                      RegWrite,
  output logic [1:0]                ResultSrc,
  output logic [1:0]                ALUsrcA,
  output logic [1:0]                ALUsrcB,
  output logic [1:0]                ImmSrc,
  output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
  output logic                      InstrRetired,
  output logic                      Illegal
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       is_store_q, is_store_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_rtype;
  alu_op_e    alu_op;
  logic       alu_valid;
  logic       unused_instr;

  assign opcode       = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign is_rtype     = (opcode == OP_RTYPE);
  // Only a subset of the instruction bits is decoded here.
  assign unused_instr = ^Instr;

  alu_decoder u_alu_decoder (
    .funct3_i   (funct3),
    .funct7b5_i (Instr[30]),
    .is_rtype_i (is_rtype),
    .alu_op_o   (alu_op),
    .valid_o    (alu_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      illegal_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      is_store_q <= is_store_d;
    end
  end

  // Load/store kind is captured in DECODE so MEMADR does not depend on
  // Instr, which is only guaranteed meaningful in the decode/execute states.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD: begin
            state_d    = S_MEMADR;
            is_store_d = 1'b0;
          end
          OP_STORE: begin
            state_d    = S_MEMADR;
            is_store_d = 1'b1;
          end
          OP_RTYPE:  state_d = alu_valid ? S_EXEC_R : S_ILLEGAL;
          OP_ITYPE:  state_d = alu_valid ? S_EXEC_I : S_ILLEGAL;
          OP_BRANCH: state_d = (funct3 == F3_BEQ || funct3 == F3_BNE) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = is_store_q ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  always_comb begin
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    AdrSrc       = ADR_PC;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUsrcA      = SRCA_PC;
    ALUsrcB      = SRCB_RS2;
    ImmSrc       = IMM_I;
    ALUctrl      = ALU_CTRL_WIDTH'(ALU_ADD);
    InstrRetired = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUsrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = SRCB_IMM;
        ImmSrc  = is_store_q ? IMM_S : IMM_I;
      end
      S_MEMREAD: AdrSrc = ADR_ALUOUT;
      S_MEMWB: begin
        ResultSrc    = RES_MDR;
        RegWrite     = 1'b1;
        InstrRetired = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc       = ADR_ALUOUT;
        MemWrite     = 1'b1;
        InstrRetired = MemReady;
      end
      S_EXEC_R: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = SRCB_RS2;
        ALUctrl = ALU_CTRL_WIDTH'(alu_op);
      end
      S_EXEC_I: begin
        ALUsrcA = SRCA_RS1;
        ALUsrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        ALUctrl = ALU_CTRL_WIDTH'(alu_op);
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        InstrRetired = 1'b1;
      end
      S_BRANCH: begin
        ALUsrcA      = SRCA_RS1;
        ALUsrcB      = SRCB_RS2;
        ALUctrl      = ALU_CTRL_WIDTH'(ALU_SUB);
        InstrRetired = 1'b1;
        PCWrite      = (funct3 == F3_BNE) ? ~EQ : EQ;
      end
      S_JAL: begin
        ALUsrcA = SRCA_OLDPC;
        ALUsrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;  // ILLEGAL: every enable stays low
    endcase
  end

  assign Illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] Instr;
  logic        EQ;
  logic        MemReady;
  logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUsrcA, ALUsrcB, ImmSrc;
  logic [2:0]  ALUctrl;
  logic        InstrRetired, Illegal;
  logic [17:0] outv;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control_unit #(.DATA_WIDTH(32), .ALU_CTRL_WIDTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .Instr        (Instr),
    .EQ           (EQ),
    .MemReady     (MemReady),
    .PCWrite      (PCWrite),
    .IRWrite      (IRWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUsrcA      (ALUsrcA),
    .ALUsrcB      (ALUsrcB),
    .ImmSrc       (ImmSrc),
    .ALUctrl      (ALUctrl),
    .InstrRetired (InstrRetired),
    .Illegal      (Illegal)
  );

  assign outv = {PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
                 ALUsrcA, ALUsrcB, ImmSrc, ALUctrl, InstrRetired, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcw,irw,adr,mw,rw,res[2],srca[2],srcb[2],imm[2],alu[3],ret,ill}
  function automatic logic [17:0] ov(input logic pcw, input logic irw,
                                     input logic adr, input logic mw,
                                     input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] alu,
                                     input logic ret, input logic ill);
    return {pcw, irw, adr, mw, rw, rs, sa, sb, imm, alu, ret, ill};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply inputs just after a falling edge, check outputs 1 ns later,
  // then let one rising edge pass.
  task automatic cyc(input string tag, input logic mr, input logic eq, input logic [17:0] exp);
    MemReady = mr;
    EQ       = eq;
    #1;
    chk(tag, outv, exp);
    @(negedge clk);
  endtask

  logic [17:0] E_F1, E_F0, E_DEC, E_DECJ, E_EXR_ADD, E_EXR_SUB, E_EXI_XOR;
  logic [17:0] E_ALUWB, E_MA_LD, E_MA_ST, E_MR, E_MWB, E_MW0, E_MW1;
  logic [17:0] E_BR_T, E_BR_N, E_JAL, E_ILL;

  localparam logic [31:0] I_ADD  = 32'h003100B3;  // add  x1,x2,x3
  localparam logic [31:0] I_SUB  = 32'h403100B3;  // sub  x1,x2,x3
  localparam logic [31:0] I_XORI = 32'h0050C193;  // xori x3,x1,5
  localparam logic [31:0] I_LW   = 32'h0080A283;  // lw   x5,8(x1)
  localparam logic [31:0] I_SW   = 32'h0050A423;  // sw   x5,8(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463;  // beq  x1,x2,+8
  localparam logic [31:0] I_BNE  = 32'h00209463;  // bne  x1,x2,+8
  localparam logic [31:0] I_JAL  = 32'h010000EF;  // jal  x1,+16
  localparam logic [31:0] I_SLTU = 32'h003130B3;  // sltu (funct3 011)

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    E_F1      = ov(1,1,0,0,0,2'b10,2'b00,2'b10,2'b00,3'd0,0,0);
    E_F0      = ov(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'd0,0,0);
    E_DEC     = ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'd0,0,0);
    E_DECJ    = ov(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'd0,0,0);
    E_EXR_ADD = ov(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'd0,0,0);
    E_EXR_SUB = ov(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'd1,0,0);
    E_EXI_XOR = ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'd4,0,0);
    E_ALUWB   = ov(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'd0,1,0);
    E_MA_LD   = ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'd0,0,0);
    E_MA_ST   = ov(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'd0,0,0);
    E_MR      = ov(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'd0,0,0);
    E_MWB     = ov(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'd0,1,0);
    E_MW0     = ov(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,3'd0,0,0);
    E_MW1     = ov(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,3'd0,1,0);
    E_BR_T    = ov(1,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'd1,1,0);
    E_BR_N    = ov(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'd1,1,0);
    E_JAL     = ov(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'd0,0,0);
    E_ILL     = ov(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'd0,0,1);

    rst = 1'b1; EQ = 1'b0; MemReady = 1'b0; Instr = I_ADD;
    @(negedge clk);
    cyc("rst_mr0", 0, 0, E_F0);
    cyc("rst_mr1", 1, 0, E_F1);
    rst = 1'b0;

    // add with one fetch stall, then sub, then xori
    cyc("add_fetch_stall", 0, 0, E_F0);
    cyc("add_fetch",       1, 0, E_F1);
    cyc("add_decode",      1, 0, E_DEC);
    cyc("add_exec",        1, 0, E_EXR_ADD);
    cyc("add_wb",          1, 0, E_ALUWB);
    Instr = I_SUB;
    cyc("sub_fetch",  1, 0, E_F1);
    cyc("sub_decode", 1, 0, E_DEC);
    cyc("sub_exec",   1, 0, E_EXR_SUB);
    cyc("sub_wb",     1, 0, E_ALUWB);
    Instr = I_XORI;
    cyc("xori_fetch",  1, 0, E_F1);
    cyc("xori_decode", 1, 0, E_DEC);
    cyc("xori_exec",   1, 0, E_EXI_XOR);
    cyc("xori_wb",     1, 0, E_ALUWB);

    // lw with three wait cycles in MEMREAD: 8 cycles total
    Instr = I_LW;
    cyc("lw_fetch",  1, 0, E_F1);
    cyc("lw_decode", 1, 0, E_DEC);
    cyc("lw_memadr", 1, 0, E_MA_LD);
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", 0, 0, E_MR);
    cyc("lw_memread_done", 1, 0, E_MR);
    cyc("lw_memwb",        1, 0, E_MWB);

    // sw with two wait cycles in MEMWRITE
    Instr = I_SW;
    cyc("sw_fetch",  1, 0, E_F1);
    cyc("sw_decode", 1, 0, E_DEC);
    cyc("sw_memadr", 1, 0, E_MA_ST);
    for (int i = 0; i < 2; i++) cyc("sw_memwrite_wait", 0, 0, E_MW0);
    cyc("sw_memwrite_done", 1, 0, E_MW1);

    // branches: beq EQ=1 taken, bne EQ=1 not taken, bne EQ=0 taken
    Instr = I_BEQ;
    cyc("beq_fetch",  1, 1, E_F1);
    cyc("beq_decode", 1, 1, E_DEC);
    cyc("beq_taken",  1, 1, E_BR_T);
    Instr = I_BNE;
    cyc("bne_fetch",    1, 1, E_F1);
    cyc("bne_decode",   1, 1, E_DEC);
    cyc("bne_nottaken", 1, 1, E_BR_N);
    cyc("bne2_fetch",   1, 0, E_F1);
    cyc("bne2_decode",  1, 0, E_DEC);
    cyc("bne2_taken",   1, 0, E_BR_T);

    // jal
    Instr = I_JAL;
    cyc("jal_fetch",  1, 0, E_F1);
    cyc("jal_decode", 1, 0, E_DECJ);
    cyc("jal_jump",   1, 0, E_JAL);
    cyc("jal_wb",     1, 0, E_ALUWB);

    // reset asserted mid-MEMREAD aborts the load
    Instr = I_LW;
    cyc("abort_fetch",   1, 0, E_F1);
    cyc("abort_decode",  1, 0, E_DEC);
    cyc("abort_memadr",  1, 0, E_MA_LD);
    cyc("abort_memread", 0, 0, E_MR);
    rst = 1'b1;
    cyc("abort_rst_mr0", 0, 0, E_F0);
    cyc("abort_rst_mr1", 1, 0, E_F1);
    rst = 1'b0;
    cyc("abort_refetch", 1, 0, E_F1);
    cyc("abort_decode2", 1, 0, E_DEC);
    cyc("abort_memadr2", 1, 0, E_MA_LD);
    cyc("abort_memread2", 1, 0, E_MR);
    cyc("abort_memwb2",   1, 0, E_MWB);

    // opcode 0000000 -> ILLEGAL, sticky until reset
    Instr = 32'h0000_0000;
    cyc("ill_fetch",  1, 0, E_F1);
    cyc("ill_decode", 1, 0, E_DEC);
    cyc("ill_state",  1, 0, E_ILL);
    cyc("ill_sticky", 1, 1, E_ILL);
    cyc("ill_sticky2", 0, 0, E_ILL);
    rst = 1'b1;
    cyc("ill_rst", 0, 0, E_F0);
    rst = 1'b0;

    // unsupported ALU funct3 and branch funct3
    Instr = I_SLTU;
    cyc("sltu_fetch",  1, 0, E_F1);
    cyc("sltu_decode", 1, 0, E_DEC);
    cyc("sltu_ill",    1, 0, E_ILL);
    rst = 1'b1;
    cyc("sltu_rst", 1, 0, E_F1);
    rst = 1'b0;
    Instr = 32'h0020A463;  // branch funct3 010
    cyc("brf3_fetch",  1, 0, E_F1);
    cyc("brf3_decode", 1, 0, E_DEC);
    cyc("brf3_ill",    1, 0, E_ILL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Control unit for the multi-cycle RISC-V core, the successor of the single-cycle controller. A Moore/Mealy FSM sequences each instruction over 3–5 cycles: fetch, decode, execute, memory, writeback. It drives the shared-memory address mux, the ALU operand muxes and the result mux. It supports R/I ALU ops, loads, stores, BEQ/BNE and JAL, and stalls on a memory ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction width (≥32; only bits [31:0] decoded)
- ALU_CTRL_WIDTH, 3, ALU operation code width (≥3)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- Instr  in  DATA_WIDTH  instruction register contents (stable from DECODE onward)
- EQ  in  1  ALU zero flag
- MemReady  in  1  shared memory completes current access this cycle
- PCWrite  out  1  load PC from result bus
- IRWrite  out  1  load instruction register (and OldPC)
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write request
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=memory data reg, 10=ALU result
- ALUsrcA  out  2  00=PC, 01=OldPC, 10=rs1
- ALUsrcB  out  2  00=rs2, 01=imm, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
- ALUctrl  out  ALU_CTRL_WIDTH  ADD=0,SUB=1,AND=2,OR=3,XOR=4,SLT=5,SLL=6,SRL=7
- InstrRetired  out  1  one-cycle pulse in an instruction's final cycle
- Illegal  out  1  sticky: unsupported instruction decoded

## Operation
Unlisted outputs are 0 in each state; ALUctrl defaults to ADD.
- FETCH: AdrSrc=0, ALUsrcA=00, ALUsrcB=10, ResultSrc=10; IRWrite=PCWrite=MemReady. Advances to DECODE when MemReady=1; otherwise stays.
- DECODE: ALUsrcA=01, ALUsrcB=01; ImmSrc=11 if JAL, else 10. Precomputes the branch/jump target into ALUOut. Next state by opcode:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - otherwise, or unsupported funct3 (ALU funct3=011; branch funct3∉{000,001}) → ILLEGAL
- MEMADR: ALUsrcA=10, ALUsrcB=01, ImmSrc=00 (load) / 01 (store). Next MEMREAD (load) or MEMWRITE (store).
- MEMREAD: AdrSrc=1; holds until MemReady → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrRetired=1 → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until MemReady. InstrRetired=MemReady. MemReady → FETCH.
- EXEC_R: ALUsrcA=10, ALUsrcB=00 → ALUWB.
- EXEC_I: ALUsrcA=10, ALUsrcB=01, ImmSrc=00 → ALUWB.
- ALU decode by funct3: 000 ADD (SUB if R-type and funct7[5]); 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 SRL.
- ALUWB: ResultSrc=00, RegWrite=1, InstrRetired=1 → FETCH.
- BRANCH: ALUsrcA=10, ALUsrcB=00, ALUctrl=SUB, ResultSrc=00, InstrRetired=1 → FETCH.
  - PCWrite = EQ for funct3=000 (BEQ), !EQ for 001 (BNE).
- JAL: ALUsrcA=01, ALUsrcB=10, ResultSrc=00, PCWrite=1 → ALUWB (ALUOut ← OldPC+4 for the link write).
- ILLEGAL: Illegal=1; terminal until rst; all write enables 0.

## Timing
- Reset: state=FETCH, Illegal=0. While rst is high, outputs equal FETCH values with PCWrite=IRWrite=MemReady.
- rst asserted mid-instruction aborts immediately, with no further writes.
- State and Illegal are registered. Outputs are combinational from state; PCWrite/IRWrite/InstrRetired also depend on MemReady or EQ in the cycle itself.
- Latency with MemReady tied to 1: R/I 4, load 5, store 4, branch 3, JAL 4 cycles.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held constant during a stall.
- Instr is sampled only in DECODE and EXEC_*/BRANCH; changes in other states are ignored.

## Structure
- Package ctrl_pkg: state enum, opcode constants, ALU op codes, mux select encodings.
- Sub-module alu_decoder: combinational, maps funct3/funct7[5]/is_rtype to ALUctrl plus a valid flag used by DECODE for ILLEGAL.

## Test plan
- rst=1 mid-MEMREAD, MemReady=0 → state FETCH next cycle, Illegal=0, RegWrite=0; 1 after release with MemReady=1 → IRWrite=PCWrite=1.
- `add x1,x2,x3`, MemReady=1 → states FETCH,DECODE,EXEC_R,ALUWB; ALUctrl=ADD in EXEC_R; RegWrite only in cycle 4. Then `sub` (funct7[5]=1) → ALUctrl=SUB.
- `lw`, MemReady low 3 cycles in MEMREAD → AdrSrc=1 held 4 cycles, then MEMWB with ResultSrc=01 and InstrRetired=1; 8 cycles total.
- `sw` → MemWrite=1 exactly through MEMWRITE until MemReady; ImmSrc=01 in MEMADR.
- `beq` with EQ=1 → PCWrite=1 in BRANCH; `bne` with EQ=1 → PCWrite=0; both 3 cycles.
- `jal` → ImmSrc=11 in DECODE, PCWrite=1 in JAL, RegWrite in ALUWB. Opcode 0000000 → ILLEGAL, Illegal=1 until rst.
